ddr_capture_pipe: RTL and testbench

- Parametrised multi-bit successor of the team's single-bit dual-edge flop.
- Captures a WIDTH-bit bus on both clock edges using the XOR-pair technique: a posedge half P and a negedge half N, with output P^N. No clock muxing or clock gating.
- Chains STAGES such captures as a half-cycle delay line.
- Adds enable, a runtime SDR/DDR mode, synchronous reset, and a posedge-aligned demux that presents each rise/fall sample pair to single-rate logic downstream.

---
 rtl/ddr_capture_pipe.sv | 113 +++++++++++
 tb/tb_ddr_capture_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ddr_capture_pipe.sv
// Dual-edge capture delay line built from XOR-pair halves, plus a posedge-aligned
// rise/fall demux so single-rate logic can consume each DDR sample pair.

module ddr_capture_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rst_r,
   input  logic             pos_en,
   input  logic             neg_en,
   input  logic [WIDTH-1:0] src,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] n;

   // Each half stores the new value XORed with the other half, so p^n is the last capture.
   always_ff @(posedge clk) begin
      if (rst)         p <= n;
      else if (pos_en) p <= src ^ n;
   end

   always_ff @(negedge clk) begin
      if (rst_r)       n <= p;
      else if (neg_en) n <= src ^ p;
   end

   assign q = p ^ n;
endmodule

module ddr_capture_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 1,
   parameter int CNT_W  = $clog2(STAGES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ddr_mode,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rise_data,
   output logic [WIDTH-1:0] fall_data,
   output logic             pair_valid
);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(STAGES);

   logic             rst_r;
   logic             mode_r;
   logic             neg_en;
   logic [WIDTH-1:0] chain [STAGES+1];
   logic [WIDTH-1:0] x_data;
   logic             neg_act;
   logic             pos_act;
   logic             pos_mode;
   logic             full_r;
   logic [CNT_W-1:0] fill;
   logic [CNT_W-1:0] fill_now;

   assign chain[0] = d;
   assign neg_en   = en & mode_r;
   assign q        = chain[STAGES];

   generate
      for (genvar s = 1; s <= STAGES; s++) begin : g_stage
         ddr_capture_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .rst_r (rst_r),
            .pos_en(en),
            .neg_en(neg_en),
            .src   (chain[s-1]),
            .q     (chain[s])
         );
      end
   endgenerate

   // fill only lives in the posedge domain; the last negedge's activity is folded in here.
   always_comb begin
      fill_now = fill;
      if (neg_act && fill != FULL) fill_now = fill + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      rst_r  <= rst;
      mode_r <= ddr_mode;
      if (rst) begin
         fill       <= '0;
         rise_data  <= '0;
         fall_data  <= '0;
         pair_valid <= 1'b0;
         pos_act    <= 1'b0;
         pos_mode   <= 1'b0;
         full_r     <= 1'b0;
      end else begin
         rise_data  <= x_data;
         fall_data  <= q;
         pair_valid <= pos_act & pos_mode & neg_act & full_r;
         pos_act    <= en;
         pos_mode   <= mode_r;
         full_r     <= (fill_now == FULL);
         if (en && fill_now != FULL) fill <= fill_now + CNT_W'(1);
         else                        fill <= fill_now;
      end
   end

   // x_data holds the posedge capture; neg_act records whether this negedge captured.
   always_ff @(negedge clk) begin
      x_data  <= q;
      neg_act <= en & mode_r & ~rst_r;
   end
endmodule

// File: tb/tb_ddr_capture_pipe.sv
// Two pipes (1 and 3 stages) share stimulus; a sample-history model feeds per-edge
// scoreboards that a separate monitor drains just after every clock edge.

module tb_ddr_capture_pipe;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       ddr_mode = 1'b1;
   logic [7:0] d = 8'h00;
   logic [7:0] q1, r1, f1, q3, r3, f3;
   logic       v1, v3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ddr_capture_pipe #(.WIDTH(8), .STAGES(1)) u_p1 (
      .clk(clk), .rst(rst), .en(en), .ddr_mode(ddr_mode), .d(d),
      .q(q1), .rise_data(r1), .fall_data(f1), .pair_valid(v1));

   ddr_capture_pipe #(.WIDTH(8), .STAGES(3)) u_p3 (
      .clk(clk), .rst(rst), .en(en), .ddr_mode(ddr_mode), .d(d),
      .q(q3), .rise_data(r3), .fall_data(f3), .pair_valid(v3));

   typedef struct packed {
      logic [7:0] q;
      logic [7:0] rise;
      logic [7:0] fall;
      logic       pv;
   } obs_t;

   obs_t sb1[$];
   obs_t sb3[$];

   // Reference model: the last S active-edge samples, newest first; q is the oldest.
   int         m_s [2] = '{1, 3};
   logic [7:0] m_hist [2][3];
   int         m_fill [2];
   logic [7:0] m_x [2], m_rise [2], m_fall [2];
   bit         m_pv [2], m_pos_act [2], m_pos_mode [2], m_full [2], m_neg_act [2];
   bit         m_mode_r = 1'b0, m_rst_r = 1'b0, live = 1'b0;

   function automatic logic [7:0] mq(input int k);
      return m_hist[k][m_s[k]-1];
   endfunction

   task automatic capture(input int k);
      for (int j = m_s[k] - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
      m_hist[k][0] = d;
      if (m_fill[k] < m_s[k]) m_fill[k]++;
   endtask

   task automatic push_exp();
      obs_t e;
      if (!live) return;
      e = '{q: mq(0), rise: m_rise[0], fall: m_fall[0], pv: m_pv[0]};
      sb1.push_back(e);
      e = '{q: mq(1), rise: m_rise[1], fall: m_fall[1], pv: m_pv[1]};
      sb3.push_back(e);
   endtask

   task automatic model_pos();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            for (int j = 0; j < 3; j++) m_hist[k][j] = 8'h00;
            m_fill[k] = 0; m_rise[k] = 8'h00; m_fall[k] = 8'h00;
            m_pv[k] = 1'b0; m_pos_act[k] = 1'b0;
         end else begin
            // The pair closing now: previous posedge + intervening negedge.
            m_pv[k]       = m_pos_act[k] && m_pos_mode[k] && m_neg_act[k] && m_full[k];
            m_rise[k]     = m_x[k];
            m_fall[k]     = mq(k);
            m_full[k]     = (m_fill[k] == m_s[k]);
            m_pos_act[k]  = en;
            m_pos_mode[k] = m_mode_r;
            if (en) capture(k);
         end
      end
      m_mode_r = ddr_mode;
      m_rst_r  = rst;
      if (rst) live = 1'b1;
      push_exp();
   endtask

   task automatic model_neg();
      for (int k = 0; k < 2; k++) begin
         m_x[k]       = mq(k);
         m_neg_act[k] = en && m_mode_r && !m_rst_r;
         if (m_neg_act[k]) capture(k);
      end
      push_exp();
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   // Monitor: compares outputs shortly after every edge against queued expectations.
   initial begin
      obs_t e;
      forever begin
         @(clk);
         #1;
         if (sb1.size() > 0) begin
            e = sb1.pop_front();
            chk("p1_q", q1, e.q);
            chk("p1_rise", r1, e.rise);
            chk("p1_fall", f1, e.fall);
            chk("p1_pair_valid", {7'd0, v1}, {7'd0, e.pv});
         end
         if (sb3.size() > 0) begin
            e = sb3.pop_front();
            chk("p3_q", q3, e.q);
            chk("p3_rise", r3, e.rise);
            chk("p3_fall", f3, e.fall);
            chk("p3_pair_valid", {7'd0, v3}, {7'd0, e.pv});
         end
      end
   end

   // One clock: values for the posedge, then values for the following negedge.
   task automatic cyc(input logic [7:0] dp, input logic [7:0] dn, input logic ep,
                      input logic en_n, input logic mp, input logic rp);
      d = dp; en = ep; ddr_mode = mp; rst = rp;
      @(posedge clk);
      model_pos();
      #2;
      d = dn; en = en_n;
      @(negedge clk);
      model_neg();
      #2;
   endtask

   initial begin
      logic       mode_sel;
      logic [7:0] dp, dn;
      mode_sel = 1'b1;

      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);

      // Basic DDR pair: 0x11 rise / 0x22 fall, closed by the 0x33 posedge.
      cyc(8'h01, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(8'h11, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(8'h33, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0);

      // Incrementing stream after a fresh reset: fill ramp and (even, odd) pairs.
      cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++)
         cyc(8'(2*i), 8'(2*i+1), 1'b1, 1'b1, 1'b1, 1'b0);

      // SDR mode with data toggling every half-cycle.
      for (int i = 0; i < 8; i++) cyc(8'hAA, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);

      // Enable gap for one full cycle while holding 0x5A.
      for (int i = 0; i < 3; i++) cyc(8'h5A, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cyc(8'h60 + 8'(i), 8'h70 + 8'(i), 1'b1, 1'b1, 1'b1, 1'b0);

      // Single-posedge reset mid-stream with 0xA5 in flight.
      for (int i = 0; i < 3; i++) cyc(8'hA5, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(8'h12, 8'h34, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) cyc(8'hC0 + 8'(i), 8'hD0 + 8'(i), 1'b1, 1'b1, 1'b1, 1'b0);

      // Randomised traffic.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) mode_sel = ~mode_sel;
         dp = 8'($urandom);
         dn = 8'($urandom);
         cyc(dp, dn, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, mode_sel,
             $urandom_range(0, 31) == 0);
      end

      repeat (2) @(clk);
      #3;
      checks++;
      if (sb1.size() != 0 || sb3.size() != 0 || checks < 100) begin
         errors++;
         $display("FAIL scoreboard_drain: left %0d/%0d entries, %0d checks", sb1.size(), sb3.size(), checks);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
